// File: rtl/bus_mem_responder.sv
// bus_mem_responder
//   Responder end of the CPU data/instruction bus. Accepts one request at a
//   time, performs it against an internal word-organised RAM after LATENCY
//   cycles, and returns a one-cycle response pulse with right-aligned,
//   zero-extended read data.
//
// Parameters
//   ADDR_BITS  word-address width; RAM depth is 2**ADDR_BITS 32-bit words
//   LATENCY    cycles from request capture to response (1..15)
//   BASE_ADDR  byte address of RAM word 0 (4-byte aligned)
//
// Ports
//   i_clk            clock, rising edge
//   i_rst            synchronous active-high reset
//   i_bus_data       write data, right-aligned
//   i_bus_address    byte address
//   i_bus_DV         request strobe, one cycle per request
//   i_bhw            access size one-hot: 001 byte, 010 half, 100 word
//   i_write_notread  1 = write, 0 = read
//   o_bus_data       read data (holds until next read or error response)
//   o_bus_DV         one-cycle response pulse
//   o_err            request rejected (qualified by o_bus_DV)
//   o_busy           request in flight; new strobes are ignored
//
// Build option
//   BUS_MEM_BOUNDS_CHECK_EN  when defined, addresses outside
//   [BASE_ADDR, BASE_ADDR + 4*2**ADDR_BITS) are rejected; otherwise the
//   word index simply wraps through the address space.

module bus_mem_responder #(
  parameter int unsigned ADDR_BITS = 12,
  parameter int unsigned LATENCY   = 2,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_bus_data,
  input  logic [31:0] i_bus_address,
  input  logic        i_bus_DV,
  input  logic [2:0]  i_bhw,
  input  logic        i_write_notread,
  output logic [31:0] o_bus_data,
  output logic        o_bus_DV,
  output logic        o_err,
  output logic        o_busy
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_WAIT    = 2'd1;
  localparam logic [1:0] S_RESPOND = 2'd2;

  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);
  localparam int unsigned DEPTH = 1 << ADDR_BITS;

  // --------------------------------------------------------------------------
  // State and captured request
  // --------------------------------------------------------------------------
  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q;
  logic [31:0] data_q;
  logic [2:0]  bhw_q;
  logic        wr_q;
  logic        err_q;
  logic [31:0] rdata_q;

  logic [31:0] mem [DEPTH];

  logic is_idle;
  logic accept;
  logic commit;

  assign is_idle = (state_q == S_IDLE);
  assign accept  = is_idle && i_bus_DV;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_bus_DV) begin
          cnt_d = LAT_M1;
          if (LATENCY == 1) begin
            state_d = S_RESPOND;
            commit  = 1'b1;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd1) begin
          cnt_d   = '0;
          state_d = S_RESPOND;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESPOND: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Access decode. With LATENCY=1 the access commits on the capture edge,
  // so the live bus inputs are used instead of the capture registers.
  // --------------------------------------------------------------------------
  logic [31:0] acc_addr;
  logic [31:0] acc_data;
  logic [2:0]  acc_bhw;
  logic        acc_wr;

  assign acc_addr = is_idle ? i_bus_address   : addr_q;
  assign acc_data = is_idle ? i_bus_data      : data_q;
  assign acc_bhw  = is_idle ? i_bhw           : bhw_q;
  assign acc_wr   = is_idle ? i_write_notread : wr_q;

  logic [31:0]          offset;
  logic [ADDR_BITS-1:0] idx;
  logic                 size_ok;
  logic                 misalign;
  logic                 oob;
  logic                 req_err;

  // Unsigned wrap makes addresses below BASE_ADDR look huge, so a single
  // upper-bits test covers both ends of the window.
  assign offset = acc_addr - BASE_ADDR;
  assign idx    = offset[ADDR_BITS+1:2];

`ifdef BUS_MEM_BOUNDS_CHECK_EN
  assign oob = ((offset >> (ADDR_BITS + 2)) != 32'd0);
`else
  logic unused_offset;
  assign oob           = 1'b0;
  assign unused_offset = ^offset;
`endif

  always_comb begin
    size_ok  = (acc_bhw == 3'b001) || (acc_bhw == 3'b010) || (acc_bhw == 3'b100);
    misalign = ((acc_bhw == 3'b010) && acc_addr[0]) ||
               ((acc_bhw == 3'b100) && (acc_addr[1:0] != 2'b00));
    req_err  = !size_ok || misalign || oob;
  end

  // Byte-lane enables and lane-replicated write data
  logic [3:0]  be;
  logic [31:0] wlane;

  always_comb begin
    be    = '0;
    wlane = '0;
    case (acc_bhw)
      3'b001: begin
        be    = 4'b0001 << acc_addr[1:0];
        wlane = {4{acc_data[7:0]}};
      end
      3'b010: begin
        be    = acc_addr[1] ? 4'b1100 : 4'b0011;
        wlane = {2{acc_data[15:0]}};
      end
      3'b100: begin
        be    = 4'b1111;
        wlane = acc_data;
      end
      default: begin
        be    = '0;
        wlane = '0;
      end
    endcase
  end

  // Read formatting: extract the addressed lane(s), zero-extended
  logic [31:0] rd_word;
  logic [31:0] rd_fmt;

  assign rd_word = mem[idx];

  always_comb begin
    rd_fmt = '0;
    case (acc_bhw)
      3'b001: begin
        case (acc_addr[1:0])
          2'd0:    rd_fmt = {24'd0, rd_word[7:0]};
          2'd1:    rd_fmt = {24'd0, rd_word[15:8]};
          2'd2:    rd_fmt = {24'd0, rd_word[23:16]};
          default: rd_fmt = {24'd0, rd_word[31:24]};
        endcase
      end
      3'b010:  rd_fmt = acc_addr[1] ? {16'd0, rd_word[31:16]} : {16'd0, rd_word[15:0]};
      3'b100:  rd_fmt = rd_word;
      default: rd_fmt = '0;
    endcase
  end

  // --------------------------------------------------------------------------
  // RAM: no reset on contents; a reset on the commit edge cancels the write.
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (!i_rst && commit && acc_wr && !req_err) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (be[i]) begin
          mem[idx][8*i +: 8] <= wlane[8*i +: 8];
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Control and response registers
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      bhw_q   <= '0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        addr_q <= i_bus_address;
        data_q <= i_bus_data;
        bhw_q  <= i_bhw;
        wr_q   <= i_write_notread;
      end
      if (commit) begin
        err_q <= req_err;
        if (req_err) begin
          rdata_q <= '0;
        end else if (!acc_wr) begin
          rdata_q <= rd_fmt;
        end
      end
    end
  end

  assign o_bus_DV   = (state_q == S_RESPOND);
  assign o_err      = o_bus_DV && err_q;
  assign o_busy     = !is_idle;
  assign o_bus_data = rdata_q;

endmodule

// File: tb/tb_bus_mem_responder.sv
// Scoreboard bench for bus_mem_responder. Three instances: default
// parameters, LATENCY=3, and a 16-word RAM at BASE_ADDR=0x1000 for range
// behaviour. Expected responses are queued at issue time and popped by a
// monitor whenever any instance raises o_bus_DV.

module tb_bus_mem_responder;

  typedef struct {
    string       nm;
    int          dut;
    logic [31:0] data;
    logic        err;
    int          cyc;
  } resp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  logic [31:0] bd [3];
  logic [31:0] ba [3];
  logic        bv [3];
  logic [2:0]  bb [3];
  logic        bw [3];
  logic [31:0] od [3];
  logic        ov [3];
  logic        oe [3];
  logic        ob [3];

  resp_t sb[$];
  resp_t me;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bus_mem_responder #(.ADDR_BITS(12), .LATENCY(2), .BASE_ADDR(32'h0000_0000)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_bus_data(bd[0]), .i_bus_address(ba[0]),
    .i_bus_DV(bv[0]), .i_bhw(bb[0]), .i_write_notread(bw[0]),
    .o_bus_data(od[0]), .o_bus_DV(ov[0]), .o_err(oe[0]), .o_busy(ob[0]));

  bus_mem_responder #(.ADDR_BITS(12), .LATENCY(3), .BASE_ADDR(32'h0000_0000)) u_lat3 (
    .i_clk(clk), .i_rst(rst), .i_bus_data(bd[1]), .i_bus_address(ba[1]),
    .i_bus_DV(bv[1]), .i_bhw(bb[1]), .i_write_notread(bw[1]),
    .o_bus_data(od[1]), .o_bus_DV(ov[1]), .o_err(oe[1]), .o_busy(ob[1]));

  bus_mem_responder #(.ADDR_BITS(4), .LATENCY(2), .BASE_ADDR(32'h0000_1000)) u_small (
    .i_clk(clk), .i_rst(rst), .i_bus_data(bd[2]), .i_bus_address(ba[2]),
    .i_bus_DV(bv[2]), .i_bhw(bb[2]), .i_write_notread(bw[2]),
    .o_bus_data(od[2]), .o_bus_DV(ov[2]), .o_err(oe[2]), .o_busy(ob[2]));

  function automatic int lat_of(input int d);
    return (d == 1) ? 3 : 2;
  endfunction

  // Monitor: every response must match the head of the scoreboard.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (ov[i] !== 1'b0) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL unexpected_dv dut%0d cyc=%0d got data=%h err=%b want no response",
                   i, cyc, od[i], oe[i]);
        end else begin
          me = sb.pop_front();
          if (me.dut != i || od[i] !== me.data || oe[i] !== me.err || cyc != me.cyc) begin
            bad++;
            $display("FAIL %s dut%0d got data=%h err=%b cyc=%0d want dut%0d data=%h err=%b cyc=%0d",
                     me.nm, i, od[i], oe[i], cyc, me.dut, me.data, me.err, me.cyc);
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  // One request; returns at cycle T+LATENCY so the next call lands on T+LATENCY+1.
  task automatic issue(input int d, input string nm, input logic wr, input logic [2:0] bhw,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] ed, input logic ee);
    resp_t r;
    @(negedge clk);
    bd[d] = wd; ba[d] = addr; bb[d] = bhw; bw[d] = wr; bv[d] = 1'b1;
    r.nm = nm; r.dut = d; r.data = ed; r.err = ee; r.cyc = cyc + lat_of(d);
    sb.push_back(r);
    @(negedge clk);
    bv[d] = 1'b0;
    repeat (lat_of(d) - 1) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout cyc=%0d want completion", cyc);
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 3; i++) begin
      bd[i] = '0; ba[i] = '0; bv[i] = 1'b0; bb[i] = 3'b100; bw[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_data", od[0], 32'h0);
    chk("rst_dv",   {31'd0, ov[0]}, 32'h0);
    chk("rst_err",  {31'd0, oe[0]}, 32'h0);
    chk("rst_busy", {31'd0, ob[0]}, 32'h0);

    // Basic word / byte / half traffic, LATENCY=2
    issue(0, "wr_word_10",  1'b1, 3'b100, 32'h10, 32'hDEADBEEF, 32'h0,        1'b0);
    issue(0, "rd_word_10",  1'b0, 3'b100, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0);
    issue(0, "wr_byte_11",  1'b1, 3'b001, 32'h11, 32'h0000005A, 32'hDEADBEEF, 1'b0);
    issue(0, "rd_word_10b", 1'b0, 3'b100, 32'h10, 32'h0,        32'hDEAD5AEF, 1'b0);
    issue(0, "rd_half_12",  1'b0, 3'b010, 32'h12, 32'h0,        32'h0000DEAD, 1'b0);
    issue(0, "rd_byte_13",  1'b0, 3'b001, 32'h13, 32'h0,        32'h000000DE, 1'b0);

    // Rejected requests
    issue(0, "wr_half_13_err", 1'b1, 3'b010, 32'h13, 32'h00001111, 32'h0, 1'b1);
    issue(0, "rd_byte_11",     1'b0, 3'b001, 32'h11, 32'h0, 32'h0000005A, 1'b0);
    issue(0, "rd_word_12_err", 1'b0, 3'b100, 32'h12, 32'h0, 32'h0, 1'b1);
    issue(0, "bhw_011_err",    1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 1'b1);
    issue(0, "rd_word_10c",    1'b0, 3'b100, 32'h10, 32'h0, 32'hDEAD5AEF, 1'b0);

    // Upper half write ignores data above bit 15; lower lanes untouched
    issue(0, "wr_half_12",  1'b1, 3'b010, 32'h12, 32'hABCD9999, 32'hDEAD5AEF, 1'b0);
    issue(0, "rd_word_10d", 1'b0, 3'b100, 32'h10, 32'h0,        32'h99995AEF, 1'b0);

    // Reset while a write is in WAIT
    issue(0, "wr_word_20", 1'b1, 3'b100, 32'h20, 32'hCAFEF00D, 32'h99995AEF, 1'b0);
    issue(0, "rd_word_20", 1'b0, 3'b100, 32'h20, 32'h0,        32'hCAFEF00D, 1'b0);
    @(negedge clk);
    bd[0] = 32'h12345678; ba[0] = 32'h20; bb[0] = 3'b100; bw[0] = 1'b1; bv[0] = 1'b1;
    @(negedge clk);
    bv[0] = 1'b0;
    chk("wait_busy", {31'd0, ob[0]}, 32'h1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_data", od[0], 32'h0);
    chk("midrst_dv",   {31'd0, ov[0]}, 32'h0);
    chk("midrst_err",  {31'd0, oe[0]}, 32'h0);
    chk("midrst_busy", {31'd0, ob[0]}, 32'h0);
    repeat (3) @(negedge clk);

    // Reset and strobe in the same cycle: request dropped
    bd[0] = 32'h0; ba[0] = 32'h20; bb[0] = 3'b100; bw[0] = 1'b0; bv[0] = 1'b1; rst = 1'b1;
    @(negedge clk);
    bv[0] = 1'b0; rst = 1'b0;
    chk("rstdv_busy", {31'd0, ob[0]}, 32'h0);
    repeat (4) @(negedge clk);
    issue(0, "rd_word_20_after_rst", 1'b0, 3'b100, 32'h20, 32'h0, 32'hCAFEF00D, 1'b0);

    // LATENCY=3: second strobe one cycle later is ignored
    @(negedge clk);
    begin
      resp_t r;
      bd[1] = 32'h01020304; ba[1] = 32'h4; bb[1] = 3'b100; bw[1] = 1'b1; bv[1] = 1'b1;
      r.nm = "lat3_wr"; r.dut = 1; r.data = 32'h0; r.err = 1'b0; r.cyc = cyc + 3;
      sb.push_back(r);
      chk("lat3_busy_T", {31'd0, ob[1]}, 32'h0);
    end
    @(negedge clk);
    bd[1] = 32'h0; bw[1] = 1'b0;
    chk("lat3_busy_T1", {31'd0, ob[1]}, 32'h1);
    @(negedge clk);
    bv[1] = 1'b0;
    chk("lat3_busy_T2", {31'd0, ob[1]}, 32'h1);
    @(negedge clk);
    chk("lat3_busy_T3", {31'd0, ob[1]}, 32'h1);
    @(negedge clk);
    chk("lat3_busy_T4", {31'd0, ob[1]}, 32'h0);
    issue(1, "lat3_rd", 1'b0, 3'b100, 32'h4, 32'h0, 32'h01020304, 1'b0);

    // Small RAM: 16 words at 0x1000..0x103F
    issue(2, "sm_wr_1000", 1'b1, 3'b100, 32'h1000, 32'h11223344, 32'h0, 1'b0);
    issue(2, "sm_wr_103c", 1'b1, 3'b100, 32'h103C, 32'h55AA55AA, 32'h0, 1'b0);
    issue(2, "sm_rd_103c", 1'b0, 3'b100, 32'h103C, 32'h0, 32'h55AA55AA, 1'b0);
`ifdef BUS_MEM_BOUNDS_CHECK_EN
    issue(2, "sm_rd_1040_oob", 1'b0, 3'b100, 32'h1040, 32'h0, 32'h0, 1'b1);
    issue(2, "sm_rd_1000",     1'b0, 3'b100, 32'h1000, 32'h0, 32'h11223344, 1'b0);
    issue(2, "sm_rd_0ffc_oob", 1'b0, 3'b100, 32'h0FFC, 32'h0, 32'h0, 1'b1);
    issue(2, "sm_wr_1040_oob", 1'b1, 3'b100, 32'h1040, 32'h77777777, 32'h0, 1'b1);
    issue(2, "sm_rd_1000b",    1'b0, 3'b100, 32'h1000, 32'h0, 32'h11223344, 1'b0);
`else
    issue(2, "sm_rd_1040_alias", 1'b0, 3'b100, 32'h1040, 32'h0, 32'h11223344, 1'b0);
    issue(2, "sm_rd_0ffc_alias", 1'b0, 3'b100, 32'h0FFC, 32'h0, 32'h55AA55AA, 1'b0);
    issue(2, "sm_wr_1040_alias", 1'b1, 3'b100, 32'h1040, 32'h77777777, 32'h55AA55AA, 1'b0);
    issue(2, "sm_rd_1000b",      1'b0, 3'b100, 32'h1000, 32'h0, 32'h77777777, 1'b0);
`endif

    repeat (6) @(negedge clk);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL missing_responses got pending=%0d want 0 (next %s)", sb.size(), sb[0].nm);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bus_mem_responder.md
# bus_mem_responder

Responder end of the CPU data/instruction bus: accepts single-outstanding read/write requests issued by the CPU core (`bus_data`/`bus_address`/`bus_DV`/`bhw`/`write_notread`), performs them against an internal word-organised RAM after a configurable latency, and returns a one-cycle data-valid pulse with read data. It sits between `CPU_top` and the on-chip memory map and serves both instruction fetches and load/store traffic.

## Interface
- `ADDR_BITS`, 12, word-address width; RAM depth = 2^ADDR_BITS 32-bit words.
- `LATENCY`, 2, cycles from request-capture cycle to response cycle; legal range 1..15.
- `BASE_ADDR`, 32'h0000_0000, byte address mapped to RAM word 0; must be 4-byte aligned.
- `i_clk`  input  1  clock, all logic on rising edge.
- `i_rst`  input  1  synchronous, active-high reset.
- `i_bus_data`  input  32  write data, right-aligned (byte in [7:0], half in [15:0]).
- `i_bus_address`  input  32  byte address.
- `i_bus_DV`  input  1  request strobe; one cycle per request.
- `i_bhw`  input  3  access size, one-hot: 3'b001 byte, 3'b010 half, 3'b100 word.
- `i_write_notread`  input  1  1 = write, 0 = read.
- `o_bus_data`  output  32  read data, right-aligned, zero-extended (sign extension is done by the CPU).
- `o_bus_DV`  output  1  response pulse, one cycle, for reads and writes.
- `o_err`  output  1  valid only with `o_bus_DV`; 1 = request rejected.
- `o_busy`  output  1  request in flight; new requests ignored.

## Operation
- FSM states: IDLE, WAIT, RESPOND.
- IDLE: on `i_bus_DV`=1, capture address, data, bhw, write_notread; load counter with LATENCY-1; go to RESPOND if LATENCY=1, else WAIT.
- WAIT: decrement counter; on the edge where counter is 1, perform access and go to RESPOND.
- RESPOND: `o_bus_DV`=1 for exactly one cycle, then IDLE.
- Access performed at the edge entering RESPOND: write updates RAM byte lanes; read registers `o_bus_data`.
- Byte lanes: byte uses lane addr[1:0]; half uses lanes {addr[1],0..1}; word uses all four. Unselected lanes untouched on write.
- Read formatting: byte -> {24'b0, lane}; half -> {16'b0, half}; word -> full word.
- Errors (`o_err`=1, no RAM write, `o_bus_data`=0): `i_bhw` not one-hot; half with addr[0]=1; word with addr[1:0]!=0; out-of-range address when bounds checking is enabled.
- Word index = (addr − BASE_ADDR)[ADDR_BITS+1:2], 32-bit unsigned subtraction.
- `i_bus_DV` while `o_busy`=1 (WAIT or RESPOND): ignored, not queued.

## Timing
- Request captured in cycle T; `o_bus_DV` high in cycle T+LATENCY only.
- Earliest next accepted request: cycle T+LATENCY+1.
- `o_busy` high from cycle T+1 through T+LATENCY inclusive.
- `o_bus_data` holds last read value until next read response; writes and errors: write responses leave it unchanged, error responses force 0.
- Reset values: state IDLE, `o_bus_data`=0, `o_bus_DV`=0, `o_err`=0, `o_busy`=0, counter 0. RAM contents not reset.
- Reset mid-operation: pending request discarded, no response; a write not yet committed is never committed.
- Reset and `i_bus_DV` in the same cycle: reset wins, request dropped.

## Configuration
- `BUS_MEM_BOUNDS_CHECK_EN` defined: addresses below BASE_ADDR or at/above BASE_ADDR + 4·2^ADDR_BITS respond with `o_err`=1, no write, data 0.
- Not defined: no range check; index truncates to ADDR_BITS bits, aliasing (wrapping) the RAM through the address space; only size/alignment errors remain.

## Test plan
- LATENCY=2, write word 0xDEADBEEF to 0x10, then read word 0x10 -> each `o_bus_DV` exactly 2 cycles after request, read returns 0xDEADBEEF, `o_err`=0.
- After above, write byte 0x5A to 0x11, read word 0x10 -> 0xDEAD5AEF; read half 0x12 -> 0x0000DEAD; read byte 0x13 -> 0x000000DE.
- Write half to 0x13 and read word at 0x12 -> both `o_err`=1, `o_bus_data`=0, RAM word 0x10 unchanged; `i_bhw`=3'b011 -> `o_err`=1.
- Issue second `i_bus_DV` one cycle after first (LATENCY=3) -> only one `o_bus_DV`, `o_busy` high cycles T+1..T+3.
- Assert `i_rst` in WAIT of a write of 0x12345678 to 0x20 -> no `o_bus_DV`, all outputs 0, later read of 0x20 returns prior contents.
- ADDR_BITS=4: read at BASE+0x40 -> with `BUS_MEM_BOUNDS_CHECK_EN` `o_err`=1; without it returns word at BASE+0x00.
